axis_traffic_gen: RTL and testbench

AXIS_TRAFFIC_GEN -- requirements
Module: axis_traffic_gen

---
 rtl/axis_traffic_gen.sv | 121 ++++++++++++
 tb/tb_axis_traffic_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_traffic_gen.sv
// axis_traffic_gen: AXI-Stream packet generator with an LFSR payload and round-robin TDEST, plus a receive-side packet counter.
// Define TRAFFIC_GEN_CHECK_EN to build the receive framing checker that drives err; without it err is tied low.
module axis_traffic_gen #(
    parameter int          TDATAW       = 32,
    parameter int          TDESTW       = 4,
    parameter int          NUM_DEST     = 4,
    parameter int          NUM_PACKETS  = 5,
    parameter int          PKT_LEN      = 4,
    parameter logic [7:0]  LFSR_DEFAULT = 8'h01
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [NUM_DEST-1:0] dest_mask,
    output logic                done,
    output logic [15:0]         tx_count,
    output logic [15:0]         rx_count,
    output logic                err,
    output logic                axis_m_tvalid,
    input  logic                axis_m_tready,
    output logic [TDATAW-1:0]   axis_m_tdata,
    output logic                axis_m_tlast,
    output logic [TDESTW-1:0]   axis_m_tdest,
    input  logic                axis_s_tvalid,
    output logic                axis_s_tready,
    input  logic [TDATAW-1:0]   axis_s_tdata,
    input  logic                axis_s_tlast,
    input  logic [TDESTW-1:0]   axis_s_tdest
);
    typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;
    localparam logic [8:0]  LAST_FLIT = 9'(PKT_LEN - 1);
    localparam logic [15:0] LAST_PKT  = 16'(NUM_PACKETS - 1);
    state_t              state;
    logic [7:0]          lfsr;
    logic [8:0]          flit_cnt;
    logic [NUM_DEST-1:0] mask_q;
    logic [TDESTW-1:0]   dest_ptr;
    logic [TDESTW-1:0]   next_dest;
    logic                accept;
    logic                last_flit;
    logic                unused_ok;
    function automatic logic [TDESTW-1:0] lowest(input logic [NUM_DEST-1:0] m);
        lowest = '0;
        for (int k = NUM_DEST - 1; k >= 0; k--)
            if (m[k]) lowest = TDESTW'(k);
    endfunction
    assign accept        = axis_m_tvalid & axis_m_tready;
    assign last_flit     = flit_cnt == LAST_FLIT;
    assign axis_m_tvalid = state == SEND;
    assign axis_m_tdata  = axis_m_tvalid ? TDATAW'(lfsr) : '0;
    assign axis_m_tlast  = axis_m_tvalid & last_flit;
    assign axis_m_tdest  = axis_m_tvalid ? dest_ptr : '0;
    assign unused_ok     = ^{axis_s_tdata, axis_s_tdest};
    // Next enabled destination strictly above the current one, wrapping to the lowest enabled one.
    always_comb begin
        next_dest = lowest(mask_q);
        for (int k = NUM_DEST - 1; k >= 0; k--)
            if (mask_q[k] && k > int'(dest_ptr)) next_dest = TDESTW'(k);
    end
    // Master-side run control: start handling, flit/packet counting, LFSR advance on each accepted flit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lfsr     <= LFSR_DEFAULT;
            flit_cnt <= '0;
            tx_count <= '0;
            done     <= 1'b0;
            mask_q   <= '0;
            dest_ptr <= '0;
        end else if (state != SEND) begin
            if (start && |dest_mask) begin
                state    <= SEND;
                tx_count <= '0;
                done     <= 1'b0;
                flit_cnt <= '0;
                mask_q   <= dest_mask;
                dest_ptr <= lowest(dest_mask);
            end
        end else if (accept) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (last_flit) begin
                flit_cnt <= '0;
                tx_count <= tx_count + 16'd1;
                dest_ptr <= next_dest;
                if (tx_count == LAST_PKT) begin
                    state <= FIN;
                    done  <= 1'b1;
                end
            end else begin
                flit_cnt <= flit_cnt + 9'd1;
            end
        end
    end
    // Slave side: always ready out of reset, counts received packets with saturation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            axis_s_tready <= 1'b0;
            rx_count      <= '0;
        end else begin
            axis_s_tready <= 1'b1;
            if (axis_s_tvalid && axis_s_tlast && rx_count != 16'hFFFF) rx_count <= rx_count + 16'd1;
        end
    end
`ifdef TRAFFIC_GEN_CHECK_EN
    logic [8:0] rx_flit;
    logic       err_q;
    assign err = err_q;
    // Receive framing check: TLAST must land exactly on flit PKT_LEN-1; the count restarts at every TLAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_flit <= '0;
            err_q   <= 1'b0;
        end else if (axis_s_tvalid) begin
            if (axis_s_tlast != (rx_flit == LAST_FLIT)) err_q <= 1'b1;
            rx_flit <= axis_s_tlast ? 9'd0 : rx_flit + 9'd1;
        end
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_axis_traffic_gen.sv
// tb_axis_traffic_gen: scoreboard bench for axis_traffic_gen with default parameters.
module tb_axis_traffic_gen;
    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [3:0]  dest;
    } flit_t;
    logic        clk, rst_n, start, done, err;
    logic [3:0]  dest_mask;
    logic [15:0] tx_count, rx_count;
    logic        m_tvalid, m_tready, m_tlast;
    logic [31:0] m_tdata;
    logic [3:0]  m_tdest;
    logic        s_tvalid, s_tready, s_tlast;
    logic [31:0] s_tdata;
    logic [3:0]  s_tdest;
    int          n_tests = 0;
    int          n_fail = 0;
    int          acc_cnt = 0;
    int          a0;
    bit          stall_q = 0;
    flit_t       hold, mf;
    flit_t       exp_q[$];
    logic [7:0]  m_lfsr = 8'h01;
    axis_traffic_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dest_mask(dest_mask),
        .done(done), .tx_count(tx_count), .rx_count(rx_count), .err(err),
        .axis_m_tvalid(m_tvalid), .axis_m_tready(m_tready), .axis_m_tdata(m_tdata),
        .axis_m_tlast(m_tlast), .axis_m_tdest(m_tdest),
        .axis_s_tvalid(s_tvalid), .axis_s_tready(s_tready), .axis_s_tdata(s_tdata),
        .axis_s_tlast(s_tlast), .axis_s_tdest(s_tdest)
    );
    initial clk = 0;
    always #5 clk = ~clk;
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    function automatic logic [7:0] lfsr_next(input logic [7:0] d);
        return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
    endfunction
    // Expected flits of one full run: 5 packets of 4 flits, destinations cycling through the set bits in ascending order.
    task automatic push_run(input logic [3:0] mask);
        int bits[$];
        for (int k = 0; k < 4; k++) if (mask[k]) bits.push_back(k);
        for (int p = 0; p < 5; p++)
            for (int f = 0; f < 4; f++) begin
                exp_q.push_back('{data: {24'h0, m_lfsr}, last: (f == 3), dest: 4'(bits[p % bits.size()])});
                m_lfsr = lfsr_next(m_lfsr);
            end
    endtask
    task automatic pulse_start();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
    endtask
    task automatic wait_done(input int budget, input bit rnd);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done) break;
            if (rnd) m_tready = 1'($urandom_range(0, 1));
        end
        m_tready = 1;
        check("done_reached", done, 1);
    endtask
    task automatic send_rx(input int n);
        for (int i = 0; i < n; i++) begin
            s_tvalid = 1; s_tlast = (i == n - 1); s_tdata = 32'(i);
            @(posedge clk); #1;
        end
        s_tvalid = 0; s_tlast = 0;
    endtask
    // Master-side monitor: pops the scoreboard on every handshake and checks hold stability during stalls.
    always @(negedge clk) begin
        if (!rst_n) stall_q = 0;
        else begin
            if (stall_q) begin
                check("hold_tvalid", m_tvalid, 1);
                check("hold_tdata", m_tdata, hold.data);
                check("hold_tlast", m_tlast, hold.last);
                check("hold_tdest", m_tdest, hold.dest);
            end
            if (m_tvalid && m_tready) begin
                acc_cnt++;
                if (exp_q.size() == 0) check("extra_flit", 1, 0);
                else begin
                    mf = exp_q.pop_front();
                    check("tdata", m_tdata, mf.data);
                    check("tlast", m_tlast, mf.last);
                    check("tdest", m_tdest, mf.dest);
                end
            end
            stall_q = m_tvalid && !m_tready;
            hold = '{data: m_tdata, last: m_tlast, dest: m_tdest};
        end
    end
    initial begin
        rst_n = 0; start = 0; dest_mask = 0; m_tready = 1;
        s_tvalid = 0; s_tlast = 0; s_tdata = 0; s_tdest = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_tlast", m_tlast, 0);
        check("rst_done", done, 0);
        check("rst_tx", tx_count, 0);
        check("rst_rx", rx_count, 0);
        check("rst_err", err, 0);
        check("rst_s_tready", s_tready, 0);
        rst_n = 1;
        @(posedge clk); #1;
        check("s_tready_up", s_tready, 1);
        check("idle_tvalid", m_tvalid, 0);
        // Basic run, all destinations, always ready.
        dest_mask = 4'b1111; a0 = acc_cnt;
        push_run(4'b1111);
        pulse_start();
        wait_done(200, 0);
        check("run1_tx", tx_count, 5);
        check("run1_flits", acc_cnt - a0, 20);
        check("run1_q", exp_q.size(), 0);
        // Sparse mask with random backpressure.
        dest_mask = 4'b1010; a0 = acc_cnt;
        push_run(4'b1010);
        pulse_start();
        wait_done(600, 1);
        check("run2_tx", tx_count, 5);
        check("run2_flits", acc_cnt - a0, 20);
        // Three-cycle stall in the middle of the first packet.
        dest_mask = 4'b1111; a0 = acc_cnt;
        push_run(4'b1111);
        pulse_start();
        repeat (2) @(posedge clk);
        #1 m_tready = 0;
        repeat (3) @(posedge clk);
        #1 m_tready = 1;
        wait_done(200, 0);
        check("run3_flits", acc_cnt - a0, 20);
        // Zero-mask start in FIN is ignored; starts during SEND are ignored.
        dest_mask = 4'b0000;
        pulse_start();
        repeat (3) @(posedge clk);
        #1;
        check("zmask_tvalid", m_tvalid, 0);
        check("zmask_done", done, 1);
        dest_mask = 4'b1111; a0 = acc_cnt;
        push_run(4'b1111);
        pulse_start();
        repeat (3) @(posedge clk);
        dest_mask = 4'b0001;
        pulse_start();
        repeat (4) @(posedge clk);
        pulse_start();
        wait_done(200, 0);
        repeat (5) @(posedge clk);
        #1;
        check("run4_tx", tx_count, 5);
        check("run4_flits", acc_cnt - a0, 20);
        check("run4_idle", m_tvalid, 0);
        // Receive side: one good packet, then a short one.
        send_rx(4);
        check("rx_good_cnt", rx_count, 1);
        check("rx_good_err", err, 0);
        send_rx(3);
        check("rx_short_cnt", rx_count, 2);
`ifdef TRAFFIC_GEN_CHECK_EN
        check("rx_short_err", err, 1);
`else
        check("rx_short_err", err, 0);
`endif
        // Reset in the middle of a run after six flits.
        dest_mask = 4'b1111; a0 = acc_cnt;
        push_run(4'b1111);
        pulse_start();
        for (int i = 0; i < 100 && acc_cnt < a0 + 6; i++) @(negedge clk);
        check("six_flits", acc_cnt - a0, 6);
        @(posedge clk);
        #1 rst_n = 0;
        #1;
        check("abort_tvalid", m_tvalid, 0);
        check("abort_tdata", m_tdata, 0);
        check("abort_tx", tx_count, 0);
        check("abort_rx", rx_count, 0);
        exp_q.delete();
        m_lfsr = 8'h01;
        @(posedge clk); #1 rst_n = 1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle", m_tvalid, 0);
        check("post_rst_done", done, 0);
        a0 = acc_cnt;
        push_run(4'b1111);
        pulse_start();
        #1;
        check("restart_tdata", m_tdata, 32'h01);
        wait_done(200, 0);
        check("run5_flits", acc_cnt - a0, 20);
        check("run5_tx", tx_count, 5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
